// File: rtl/multicycle_sequencer_pkg.sv
// Shared encodings for the LEGv8 multi-cycle sequencer: state codes, control-bus
// field indices and small decode helpers.
package multicycle_sequencer_pkg;

  // Control-bus field indices driven by the decoder.
  localparam int CONTROLSIZE = 5;
  localparam int REGWRITE    = 0;
  localparam int MEMREAD     = 1;
  localparam int MEMWRITE    = 2;
  localparam int MEMTOREG    = 3;
  localparam int SETFLAGS    = 4;

  localparam int SEQSTATESIZE = 3;

  typedef logic [CONTROLSIZE-1:0] ctrl_t;

  typedef enum logic [SEQSTATESIZE-1:0] {
    SEQSTATE_IDLE   = 3'd0,
    SEQSTATE_FETCH  = 3'd1,
    SEQSTATE_DECODE = 3'd2,
    SEQSTATE_EXEC   = 3'd3,
    SEQSTATE_MEM    = 3'd4,
    SEQSTATE_WB     = 3'd5,
    SEQSTATE_HALT   = 3'd6,
    SEQSTATE_FAULT  = 3'd7
  } seq_state_e;

  function automatic logic is_mem_op(input ctrl_t c);
    return c[MEMREAD] | c[MEMWRITE];
  endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Handshake and control bundle between the sequencer (master) and the
// datapath/memory side (slave).
interface multicycle_sequencer_if;
  import multicycle_sequencer_pkg::*;

  logic                    start;
  logic                    halt_req;
  ctrl_t                   ctrl;
  logic                    imem_ack;
  logic                    dmem_ack;
  logic                    imem_req;
  logic                    dmem_req;
  logic                    ir_write;
  logic                    pc_write;
  logic                    regwrite_en;
  logic                    flags_write_en;
  logic                    memread_en;
  logic                    memwrite_en;
  logic [SEQSTATESIZE-1:0] state;
  logic [31:0]             instret;
  logic                    fault;

  modport master (
    input  start, halt_req, ctrl, imem_ack, dmem_ack,
    output imem_req, dmem_req, ir_write, pc_write, regwrite_en,
           flags_write_en, memread_en, memwrite_en, state, instret, fault
  );

  modport slave (
    output start, halt_req, ctrl, imem_ack, dmem_ack,
    input  imem_req, dmem_req, ir_write, pc_write, regwrite_en,
           flags_write_en, memread_en, memwrite_en, state, instret, fault
  );

endinterface

// File: rtl/multicycle_sequencer_waittimer.sv
// Memory-wait watchdog; only present when SEQ_TIMEOUT_EN is defined.
// expired flags the wait cycle that would be the TIMEOUT_CYCLES-th without an ack.
`ifdef SEQ_TIMEOUT_EN
module multicycle_sequencer_waittimer #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CountWidth = $clog2(TIMEOUT_CYCLES + 1);

  logic [CountWidth-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count_q <= '0;
    end else if (count_en) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign expired = count_en && (count_q == CountWidth'(TIMEOUT_CYCLES - 1));

endmodule
`endif

// File: rtl/multicycle_sequencer.sv
// Multi-cycle LEGv8 sequencer: FETCH/DECODE/EXEC/MEM/WB with one-shot write strobes
// and a retired-instruction counter. SEQ_TIMEOUT_EN adds a memory-wait timeout to FAULT.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
`ifdef SEQ_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
  input  logic                   clk,
  input  logic                   rst,
  multicycle_sequencer_if.master bus
);

  seq_state_e  state_q, state_d;
  logic [31:0] instret_q;
  logic        retire;
  logic        expired;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q   <= SEQSTATE_IDLE;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instret_q <= instret_q + 32'd1;
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d            = state_q;
    retire             = 1'b0;
    bus.imem_req       = 1'b0;
    bus.dmem_req       = 1'b0;
    bus.ir_write       = 1'b0;
    bus.regwrite_en    = 1'b0;
    bus.flags_write_en = 1'b0;
    bus.memread_en     = 1'b0;
    bus.memwrite_en    = 1'b0;

    case (state_q)
      SEQSTATE_IDLE, SEQSTATE_HALT: begin
        if (bus.start) state_d = SEQSTATE_FETCH;
      end
      SEQSTATE_FETCH: begin
        bus.imem_req = 1'b1;
        if (bus.imem_ack) begin
          bus.ir_write = 1'b1;
          state_d      = SEQSTATE_DECODE;
        end else if (expired) begin
          state_d = SEQSTATE_FAULT;
        end
      end
      SEQSTATE_DECODE: state_d = SEQSTATE_EXEC;
      SEQSTATE_EXEC: begin
        bus.flags_write_en = bus.ctrl[SETFLAGS];
        if (is_mem_op(bus.ctrl))      state_d = SEQSTATE_MEM;
        else if (bus.ctrl[REGWRITE])  state_d = SEQSTATE_WB;
        else                          retire  = 1'b1;
      end
      SEQSTATE_MEM: begin
        bus.dmem_req    = 1'b1;
        bus.memread_en  = bus.ctrl[MEMREAD];
        bus.memwrite_en = bus.ctrl[MEMWRITE];
        if (bus.dmem_ack) begin
          if (bus.ctrl[MEMTOREG]) state_d = SEQSTATE_WB;
          else                    retire  = 1'b1;
        end else if (expired) begin
          state_d = SEQSTATE_FAULT;
        end
      end
      SEQSTATE_WB: begin
        bus.regwrite_en = 1'b1;
        retire          = 1'b1;
      end
      SEQSTATE_FAULT: state_d = SEQSTATE_FAULT;
      default:        state_d = SEQSTATE_IDLE;
    endcase

    // halt_req only matters in the retire cycle.
    if (retire) begin
      state_d = bus.halt_req ? SEQSTATE_HALT : SEQSTATE_FETCH;
    end
  end

  assign bus.pc_write = retire;
  assign bus.state    = state_q;
  assign bus.instret  = instret_q;

`ifdef SEQ_TIMEOUT_EN
  logic waiting;
  logic wait_ack;

  assign waiting  = (state_q == SEQSTATE_FETCH) || (state_q == SEQSTATE_MEM);
  assign wait_ack = ((state_q == SEQSTATE_FETCH) && bus.imem_ack) ||
                    ((state_q == SEQSTATE_MEM)   && bus.dmem_ack);

  // Any state change restarts the count, so each FETCH/MEM visit starts at zero.
  multicycle_sequencer_waittimer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_waittimer (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_d != state_q),
    .count_en (waiting && !wait_ack),
    .expired  (expired)
  );

  assign bus.fault = (state_q == SEQSTATE_FAULT);
`else
  assign expired   = 1'b0;
  assign bus.fault = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed self-checking bench for multicycle_sequencer; timeout cases run when
// SEQ_TIMEOUT_EN is defined (TIMEOUT_CYCLES = 4).
module tb_multicycle_sequencer;
  import multicycle_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_errors = 0;

  multicycle_sequencer_if bus ();

`ifdef SEQ_TIMEOUT_EN
  multicycle_sequencer #(.TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  multicycle_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  // Strobe vector: {imem_req, dmem_req, ir_write, pc_write, regwrite_en,
  //                 flags_write_en, memread_en, memwrite_en, fault}
  localparam logic [8:0] SB_NONE  = 9'h000;
  localparam logic [8:0] SB_IMEM  = 9'h100;
  localparam logic [8:0] SB_DMEM  = 9'h080;
  localparam logic [8:0] SB_IR    = 9'h040;
  localparam logic [8:0] SB_PC    = 9'h020;
  localparam logic [8:0] SB_RW    = 9'h010;
  localparam logic [8:0] SB_FL    = 9'h008;
  localparam logic [8:0] SB_MR    = 9'h004;
  localparam logic [8:0] SB_MW    = 9'h002;
  localparam logic [8:0] SB_FAULT = 9'h001;

  localparam ctrl_t C_BR   = 5'b00000;
  localparam ctrl_t C_ADD  = 5'b00001;  // REGWRITE
  localparam ctrl_t C_ADDS = 5'b10001;  // SETFLAGS | REGWRITE
  localparam ctrl_t C_LDUR = 5'b01011;  // MEMTOREG | MEMREAD | REGWRITE
  localparam ctrl_t C_STUR = 5'b00100;  // MEMWRITE

  function automatic logic [8:0] strobes();
    return {bus.imem_req, bus.dmem_req, bus.ir_write, bus.pc_write, bus.regwrite_en,
            bus.flags_write_en, bus.memread_en, bus.memwrite_en, bus.fault};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs for the current cycle are set before calling; checks state and
  // strobes mid-cycle, then advances to just after the next rising edge.
  task automatic cyc(input string tag, input seq_state_e st, input logic [8:0] sb);
    #1;
    check({tag, "_state"}, 32'(bus.state), 32'(st));
    check({tag, "_strobes"}, 32'(strobes()), 32'(sb));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.halt_req = 1'b0;
    bus.ctrl     = '0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_instret", bus.instret, 32'd0);
    cyc("rst", SEQSTATE_IDLE, SB_NONE);

    // ADD, zero-wait: retire in WB
    bus.ctrl = C_ADD; bus.start = 1'b1; bus.imem_ack = 1'b1; bus.dmem_ack = 1'b1;
    cyc("add_idle", SEQSTATE_IDLE, SB_NONE);
    bus.start = 1'b0;
    cyc("add_fetch", SEQSTATE_FETCH, SB_IMEM | SB_IR);
    cyc("add_dec", SEQSTATE_DECODE, SB_NONE);
    cyc("add_exec", SEQSTATE_EXEC, SB_NONE);
    cyc("add_wb", SEQSTATE_WB, SB_RW | SB_PC);
    check("add_instret", bus.instret, 32'd1);

    // LDUR with dmem_ack after 3 wait cycles: 8 cycles total
    bus.ctrl = C_LDUR; bus.dmem_ack = 1'b0;
    cyc("ld_fetch", SEQSTATE_FETCH, SB_IMEM | SB_IR);
    cyc("ld_dec", SEQSTATE_DECODE, SB_NONE);
    cyc("ld_exec", SEQSTATE_EXEC, SB_NONE);
    for (int i = 0; i < 3; i++) cyc("ld_memwait", SEQSTATE_MEM, SB_DMEM | SB_MR);
    bus.dmem_ack = 1'b1;
    cyc("ld_memack", SEQSTATE_MEM, SB_DMEM | SB_MR);
    cyc("ld_wb", SEQSTATE_WB, SB_RW | SB_PC);
    check("ld_instret", bus.instret, 32'd2);

    // Two branches: retire in EXEC, 3 cycles each
    bus.ctrl = C_BR;
    for (int i = 0; i < 2; i++) begin
      cyc("br_fetch", SEQSTATE_FETCH, SB_IMEM | SB_IR);
      cyc("br_dec", SEQSTATE_DECODE, SB_NONE);
      cyc("br_exec", SEQSTATE_EXEC, SB_PC);
      check("br_instret", bus.instret, 32'(3 + i));
    end

    // STUR: retire in MEM
    bus.ctrl = C_STUR;
    cyc("st_fetch", SEQSTATE_FETCH, SB_IMEM | SB_IR);
    cyc("st_dec", SEQSTATE_DECODE, SB_NONE);
    cyc("st_exec", SEQSTATE_EXEC, SB_NONE);
    cyc("st_mem", SEQSTATE_MEM, SB_DMEM | SB_MW | SB_PC);
    check("st_instret", bus.instret, 32'd5);

    // ADDS with halt_req high only before the retire cycle: ignored
    bus.ctrl = C_ADDS; bus.halt_req = 1'b1;
    cyc("adds_fetch", SEQSTATE_FETCH, SB_IMEM | SB_IR);
    cyc("adds_dec", SEQSTATE_DECODE, SB_NONE);
    cyc("adds_exec", SEQSTATE_EXEC, SB_FL);
    bus.halt_req = 1'b0;
    cyc("adds_wb", SEQSTATE_WB, SB_RW | SB_PC);
    check("adds_instret", bus.instret, 32'd6);

    // ADDS with halt_req in WB: HALT, then start resumes
    cyc("h_fetch", SEQSTATE_FETCH, SB_IMEM | SB_IR);
    cyc("h_dec", SEQSTATE_DECODE, SB_NONE);
    cyc("h_exec", SEQSTATE_EXEC, SB_FL);
    bus.halt_req = 1'b1;
    cyc("h_wb", SEQSTATE_WB, SB_RW | SB_PC);
    bus.halt_req = 1'b0;
    check("h_instret", bus.instret, 32'd7);
    cyc("h_halt", SEQSTATE_HALT, SB_NONE);
    bus.start = 1'b1;
    cyc("h_halt_start", SEQSTATE_HALT, SB_NONE);
    bus.start = 1'b0;

    // Reset while waiting for dmem_ack; a late ack is ignored
    bus.ctrl = C_LDUR; bus.dmem_ack = 1'b0;
    cyc("rm_fetch", SEQSTATE_FETCH, SB_IMEM | SB_IR);
    cyc("rm_dec", SEQSTATE_DECODE, SB_NONE);
    cyc("rm_exec", SEQSTATE_EXEC, SB_NONE);
    cyc("rm_mem1", SEQSTATE_MEM, SB_DMEM | SB_MR);
    rst = 1'b1;
    cyc("rm_mem2", SEQSTATE_MEM, SB_DMEM | SB_MR);
    rst = 1'b0; bus.dmem_ack = 1'b1;
    check("rm_instret", bus.instret, 32'd0);
    cyc("rm_idle", SEQSTATE_IDLE, SB_NONE);
    cyc("rm_idle_late_ack", SEQSTATE_IDLE, SB_NONE);
    bus.dmem_ack = 1'b0;

`ifdef SEQ_TIMEOUT_EN
    // imem_ack never arrives: FAULT after 4 wait cycles
    bus.start = 1'b1; bus.imem_ack = 1'b0;
    cyc("to_idle", SEQSTATE_IDLE, SB_NONE);
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) cyc("to_wait", SEQSTATE_FETCH, SB_IMEM);
    bus.start = 1'b1;
    cyc("to_fault", SEQSTATE_FAULT, SB_FAULT);
    bus.start = 1'b0; rst = 1'b1;
    cyc("to_fault_hold", SEQSTATE_FAULT, SB_FAULT);
    rst = 1'b0; bus.start = 1'b1;
    // imem_ack exactly at expiry wins
    cyc("tx_idle", SEQSTATE_IDLE, SB_NONE);
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) cyc("tx_wait", SEQSTATE_FETCH, SB_IMEM);
    bus.imem_ack = 1'b1;
    cyc("tx_ack", SEQSTATE_FETCH, SB_IMEM | SB_IR);
    cyc("tx_dec", SEQSTATE_DECODE, SB_NONE);
`else
    // Without the timeout a long fetch wait never faults
    bus.start = 1'b1; bus.imem_ack = 1'b0;
    cyc("nw_idle", SEQSTATE_IDLE, SB_NONE);
    bus.start = 1'b0;
    for (int i = 0; i < 20; i++) cyc("nw_wait", SEQSTATE_FETCH, SB_IMEM);
    bus.imem_ack = 1'b1;
    cyc("nw_ack", SEQSTATE_FETCH, SB_IMEM | SB_IR);
    cyc("nw_dec", SEQSTATE_DECODE, SB_NONE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Finite-state sequencer that turns the LEGv8 single-cycle datapath into a multi-cycle machine. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and handshakes with instruction and data memory. It gates the decoded control bus from `controlunit` so register-file, flag, memory and PC writes happen in exactly one cycle per instruction. It also counts retired instructions.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: maximum cycles a memory request may wait for its ack. Used only with `SEQ_TIMEOUT_EN`.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: leave IDLE or HALT and begin fetching.
- `halt_req` in 1: stop after the current instruction retires.
- `ctrl` in `CONTROLSIZE`: decoded control bus from `controlunit`. Fields are indexed by the `control.vh` macros.
- `imem_ack` in 1: instruction word is valid this cycle.
- `dmem_ack` in 1: data access is complete this cycle.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data memory request.
- `ir_write` out 1: latch the instruction register.
- `pc_write` out 1: update the PC; this is the retire strobe.
- `regwrite_en` out 1: register-file write enable.
- `flags_write_en` out 1: NZCV write enable.
- `memread_en` out 1: data read strobe.
- `memwrite_en` out 1: data write strobe.
- `state` out `SEQSTATESIZE`: current state, for debug.
- `instret` out 32: count of retired instructions.
- `fault` out 1: memory timeout occurred.

## Operation
- **States:** IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT.
- **IDLE:**
  - `start` → FETCH.
- **FETCH:**
  - `imem_req` is 1.
  - On `imem_ack`: `ir_write` pulses 1 in the same cycle, then → DECODE.
- **DECODE:** one cycle, → EXEC. `ctrl` must be stable from this state onward.
- **EXEC:**
  - `flags_write_en` equals `ctrl[SETFLAGS]`.
  - If `ctrl[MEMREAD]` or `ctrl[MEMWRITE]` → MEM.
  - Else if `ctrl[REGWRITE]` → WB.
  - Else retire.
- **MEM:**
  - `dmem_req` is 1.
  - `memread_en` equals `ctrl[MEMREAD]`; `memwrite_en` equals `ctrl[MEMWRITE]`.
  - On `dmem_ack`: if `ctrl[MEMTOREG]` → WB, else retire.
- **WB:**
  - `regwrite_en` is 1 for exactly one cycle, then retire.
- **Retire cycle** (last cycle of EXEC, MEM or WB):
  - `pc_write` is 1.
  - `instret` increments and wraps from 0xFFFFFFFF to 0.
  - Next state is HALT if `halt_req` is sampled high this cycle, else FETCH.
- **HALT:**
  - All strobes are 0.
  - `start` → FETCH.
- **FAULT:**
  - All strobes are 0 and `fault` is 1.
  - Exit only via `rst`.
- **Handshake rules:**
  - A request stays high until its ack.
  - An ack while the corresponding request is low is ignored.
  - The ack may arrive in the same cycle the request first rises.
- **Ignored inputs:**
  - `start` outside IDLE and HALT.
  - `halt_req` outside the retire cycle.

## Timing
- **Reset (effective next edge, also mid-instruction):**
  - `state` = IDLE; `instret` = 0.
  - Every other output is 0.
  - An in-flight request drops at that edge; a later ack is ignored.
- **Output decode:**
  - Strobes are decoded from the state register, `ctrl` and the acks in the same cycle.
  - No strobe is asserted outside its state.
- **Minimum cycles per instruction, zero-wait memory:**
  - branch: 3 (FETCH, DECODE, EXEC).
  - R/I-format: 4.
  - STUR: 4.
  - LDUR: 5.
- **Wait cycles:** each wait cycle in FETCH or MEM adds one cycle.
- **Stuck-in-state bound:** at most one stuck-in-state cycle per state apart from the memory waits.

## Configuration
- **With `SEQ_TIMEOUT_EN` defined:**
  - A wait counter of width `$clog2(TIMEOUT_CYCLES+1)` clears on entry to FETCH or MEM.
  - It increments on each cycle without an ack.
  - When it reaches `TIMEOUT_CYCLES` → FAULT and `fault` = 1.
  - An ack in the expiry cycle wins: normal transition, no fault.
- **Without it:**
  - Waits are unbounded.
  - `fault` is tied to 0 and FAULT is unreachable.
  - No counter is synthesised.

## Structure
- **Shared header `seqstate.vh`:**
  - `SEQSTATESIZE` (3).
  - `SEQSTATE_IDLE` … `SEQSTATE_FAULT` encodings; IDLE = 0.
- **Reused headers:** control field indices come from the existing `control.vh`.
- **Sub-module `waittimer`:**
  - Inputs: clear, count-enable, expired flag.
  - Instantiated only under `SEQ_TIMEOUT_EN`.

## Test plan
- **ADD, zero-wait:** `rst`, then `start`, `ctrl` with REGWRITE only, ack every cycle.
  - Required: states IDLE→FETCH→DECODE→EXEC→WB→FETCH.
  - `regwrite_en` is high for 1 cycle; `pc_write` coincides with WB.
  - `instret` = 1.
- **LDUR with 3-cycle `dmem_ack` delay:**
  - `dmem_req` is high for 4 cycles.
  - `memread_en` is high throughout MEM.
  - WB follows; the instruction totals 8 cycles.
- **Branch (no write bits set):**
  - Retire occurs in EXEC.
  - `regwrite_en` and `dmem_req` are never 1.
  - `instret` counts 1 per 3 cycles.
- **ADDS with `halt_req` asserted during the WB cycle:**
  - `flags_write_en` is high in EXEC.
  - → HALT; all strobes are 0; `start` resumes FETCH.
  - `halt_req` asserted in DECODE instead is ignored.
- **Timeout (`SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4):**
  - `imem_ack` never arrives: FAULT after 4 wait cycles, `fault` = 1, `imem_req` = 0.
  - `imem_ack` exactly at expiry: DECODE, no fault.
- **Reset mid-MEM:** `rst` asserted while waiting for `dmem_ack`.
  - Next cycle: IDLE, `dmem_req` = 0, `instret` = 0.
  - A late `dmem_ack` causes no transition.
